// File: rtl/cla_nibble_sequencer.sv
// Feeds wide operands one 4-bit slice per cycle into an external combinational CLA,
// LSB first, and collects the slice sums into a full-width result with carry and overflow.
module cla_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_sum,
  input  logic                   cla_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    in_ready  = 1'b0;
    cla_a     = 4'h0;
    cla_b     = 4'h0;
    cla_cin   = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    out_ovf   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so the handshake is closed while reset is still asserted.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        cla_cin = carry_q;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
          if (idx_q == IdxW'(n)) begin
            cla_a              = a_q[4*n +: 4];
            cla_b              = b_q[4*n +: 4];
            res_d[4*n +: 4]    = cla_sum;
          end
        end
        carry_d = cla_cout;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        out_sum   = res_q;
        out_cout  = carry_q;
        out_ovf   = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for cla_nibble_sequencer with a behavioural 4-bit CLA in the loop.
module tb_cla_nibble_sequencer;

  localparam int unsigned NIB = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic [3:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout, out_ovf;
  logic [4:0]  cla_full;

  int checks = 0;
  int errors = 0;

  res_t        sb[$];
  res_t        exp_r;
  logic        obs_got;
  logic [15:0] obs_sum;
  logic        obs_cout, obs_ovf, obs_stable, obs_after_valid, obs_after_ready;
  int          obs_lat;
  logic [3:0]  seq_a[4];
  logic [3:0]  seq_b[4];
  logic        seq_cin[4];

  always #5 clk = ~clk;

  assign cla_full = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  assign cla_sum  = cla_full[3:0];
  assign cla_cout = cla_full[4];

  cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Drives one operand set, records the slice stream and the presented result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input int hold);
    res_t        e;
    logic [15:0] beff;
    logic [16:0] full;
    int          n;
    beff   = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, beff} + (sub ? 17'd1 : {16'd0, cin});
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == beff[15]) && (full[15] != a[15]);
    obs_got = 1'b0;
    obs_stable = 1'b1;
    exp_r = '0;
    for (int k = 0; k < 4; k++) begin
      seq_a[k] = 'x; seq_b[k] = 'x; seq_cin[k] = 1'bx;
    end
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
      return;
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    obs_lat = 0;
    while (!out_valid && obs_lat < 20) begin
      if (obs_lat < 4) begin
        seq_a[obs_lat] = cla_a; seq_b[obs_lat] = cla_b; seq_cin[obs_lat] = cla_cin;
      end
      @(negedge clk);
      obs_lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%b required 1", out_valid);
      return;
    end
    obs_sum = out_sum; obs_cout = out_cout; obs_ovf = out_ovf;
    if (sb.size() > 0) begin
      exp_r = sb.pop_front();
      obs_got = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== obs_sum || in_ready !== 1'b0) obs_stable = 1'b0;
      if (h == 1) begin
        in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
      end
      if (h == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    obs_after_valid = out_valid;
    obs_after_ready = in_ready;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 || cla_a !== 4'h0 ||
        cla_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b out_sum=%h cla_a=%h required 0",
               in_ready, out_valid, out_sum, cla_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic_add;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL basic_result got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    checks++;
    if ({seq_a[0], seq_a[1], seq_a[2], seq_a[3]} !== 16'h4321) begin
      errors++;
      $display("FAIL basic_cla_a seq %h%h%h%h required 4321", seq_a[0], seq_a[1], seq_a[2],
               seq_a[3]);
    end
    checks++;
    if ({seq_b[0], seq_b[1], seq_b[2], seq_b[3]} !== 16'h1234) begin
      errors++;
      $display("FAIL basic_cla_b seq %h%h%h%h required 1234", seq_b[0], seq_b[1], seq_b[2],
               seq_b[3]);
    end
    checks++;
    if (obs_lat !== NIB) begin
      errors++;
      $display("FAIL basic_latency got %0d required %0d", obs_lat, NIB);
    end
    checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release out_valid=%b in_ready=%b required 0/1", obs_after_valid,
               obs_after_ready);
    end
  endtask

  task automatic test_ripple;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL ripple_result got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    checks++;
    if ({seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]} !== 4'b0111) begin
      errors++;
      $display("FAIL ripple_cla_cin seq %b%b%b%b required 0111", seq_cin[0], seq_cin[1],
               seq_cin[2], seq_cin[3]);
    end
  endtask

  task automatic test_overflow;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL ovf_add got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL ovf_sub got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
  endtask

  task automatic test_sub_borrow;
    run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL sub_borrow got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
  endtask

  task automatic test_backpressure;
    run_op(16'h0F0F, 16'h1010, 1'b1, 1'b0, 5);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL bp_result got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    checks++;
    if (obs_stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable got %b required 1", obs_stable);
    end
    checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", obs_after_valid,
               obs_after_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pulse_ignored out_valid=%b in_ready=%b required 0/1", out_valid,
               in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    in_a = 16'h5678; in_b = 16'h1111; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cla_a !== 4'h6 || cla_b !== 4'h1) begin
      errors++;
      $display("FAIL midrun_index cla_a=%h cla_b=%h required 6/1", cla_a, cla_b);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cla_a !== 4'h0 || cla_b !== 4'h0 || cla_cin !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b0 || out_sum !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset cla=%h/%h/%b out_valid=%b in_ready=%b sum=%h required 0",
               cla_a, cla_b, cla_cin, out_valid, in_ready, out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    checks++;
    if (!obs_got || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
      errors++;
      $display("FAIL midrun_next got %h/%b/%b required %h/%b/%b", obs_sum, obs_cout, obs_ovf,
               exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_ripple;
    test_overflow;
    test_sub_borrow;
    test_backpressure;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
